// File: rtl/fpu_op_sequencer_if.sv
// Request/response handshake bundle for the FP op sequencer.
// master = FP issue side, slave = sequencer.
interface fpu_op_sequencer_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [4:0]  req_tag;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic [4:0]  rsp_tag;
  logic        rsp_dz;
  logic        rsp_nv;

  modport master (
    output req_valid, req_op, req_a, req_b, req_tag,
    output rsp_ready,
    input  req_ready, rsp_valid, rsp_result,
    input  rsp_tag, rsp_dz, rsp_nv
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, req_tag,
    input  rsp_ready,
    output req_ready, rsp_valid, rsp_result,
    output rsp_tag, rsp_dz, rsp_nv
  );
endinterface

// File: rtl/fpu_op_sequencer.sv
// Single-issue sequencer for the shared FPU datapath.
// Waits a per-op multicycle count, then returns the unit result.
module fpu_op_sequencer #(
  parameter int ADD_LAT = 1,
  parameter int MUL_LAT = 2,
  parameter int DIV_LAT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  fpu_op_sequencer_if.slave bus,
  output logic [31:0] fpu_a,
  output logic [31:0] fpu_b,
  output logic [1:0]  fpu_sel,
  input  logic [31:0] addsub_result,
  input  logic [31:0] mul_result,
  input  logic [31:0] div_result,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    DONE
  } state_t;

  localparam logic [3:0] ADD_M1 = 4'(ADD_LAT - 1);
  localparam logic [3:0] MUL_M1 = 4'(MUL_LAT - 1);
  localparam logic [3:0] DIV_M1 = 4'(DIV_LAT - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  lat_m1;
  logic        ready_q, valid_q, busy_q;
  logic        spec_q;
  logic [1:0]  op_q;
  logic [31:0] res_q, cap_res;
  logic [4:0]  tag_q;
  logic        dz_q, nv_q;
  logic        accept, a_zero, div_zero;
  logic [1:0]  sel_d;

  assign accept   = bus.req_valid && ready_q;
  assign a_zero   = bus.req_a[30:0] == 31'd0;
  assign div_zero = (bus.req_op == 2'b11) &&
                    (bus.req_b[30:0] == 31'd0);

  assign bus.req_ready  = ready_q;
  assign bus.rsp_valid  = valid_q;
  assign bus.rsp_result = res_q;
  assign bus.rsp_tag    = tag_q;
  assign bus.rsp_dz     = dz_q;
  assign bus.rsp_nv     = nv_q;
  assign busy           = busy_q;

  // Decode the incoming op into unit select and latency.
  always_comb begin
    sel_d  = 2'd0;
    lat_m1 = ADD_M1;
    unique case (1'b1)
      bus.req_op == 2'b11: begin
        sel_d  = 2'd2;
        lat_m1 = DIV_M1;
      end
      bus.req_op == 2'b10: begin
        sel_d  = 2'd1;
        lat_m1 = MUL_M1;
      end
      default: begin
        sel_d  = 2'd0;
        lat_m1 = ADD_M1;
      end
    endcase
  end

  // Pick the unit result belonging to the latched op.
  always_comb begin
    cap_res = addsub_result;
    unique case (1'b1)
      op_q == 2'b11: cap_res = div_result;
      op_q == 2'b10: cap_res = mul_result;
      default:       cap_res = addsub_result;
    endcase
  end

  // Next state and countdown. Zero divisors spend one
  // cycle in EXEC with a zero count so that the response
  // timing matches a one-cycle op.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = EXEC;
          cnt_d   = div_zero ? 4'd0 : lat_m1;
        end
      end
      EXEC: begin
        if (cnt_q == 4'd0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        if (valid_q && bus.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with registered handshake/status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= state_d == IDLE;
      valid_q <= state_d == DONE;
      busy_q  <= state_d != IDLE;
    end
  end

  // Operand, tag and result capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fpu_a   <= 32'd0;
      fpu_b   <= 32'd0;
      fpu_sel <= 2'd0;
      op_q    <= 2'd0;
      spec_q  <= 1'b0;
      tag_q   <= 5'd0;
      res_q   <= 32'd0;
      dz_q    <= 1'b0;
      nv_q    <= 1'b0;
    end else begin
      if (accept) begin
        tag_q  <= bus.req_tag;
        op_q   <= bus.req_op;
        spec_q <= div_zero;
        if (div_zero) begin
          nv_q  <= a_zero;
          dz_q  <= !a_zero;
          res_q <= a_zero ? 32'h7FC0_0000 :
                   {bus.req_a[31] ^ bus.req_b[31],
                    8'hFF, 23'd0};
        end else begin
          fpu_a   <= bus.req_a;
          fpu_sel <= sel_d;
          fpu_b   <= (bus.req_op == 2'b01) ?
                     {~bus.req_b[31], bus.req_b[30:0]} :
                     bus.req_b;
        end
      end
      if (state_q == EXEC && cnt_q == 4'd0 && !spec_q) begin
        res_q <= cap_res;
        dz_q  <= 1'b0;
        nv_q  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fpu_op_sequencer.sv
// Self-checking bench for fpu_op_sequencer.
// Randomized ops against a transaction-level reference model.
module tb_fpu_op_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] fpu_a, fpu_b;
  logic [1:0]  fpu_sel;
  logic [31:0] addsub_result, mul_result, div_result;
  logic        busy;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [31:0] m_a, m_b;
  logic [1:0]  m_sel;
  logic [31:0] e_res;
  logic [4:0]  e_tag;
  logic        e_dz, e_nv;
  int          e_lat;

  fpu_op_sequencer_if bus ();

  fpu_op_sequencer #(
    .ADD_LAT(1),
    .MUL_LAT(2),
    .DIV_LAT(8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus.slave),
    .fpu_a        (fpu_a),
    .fpu_b        (fpu_b),
    .fpu_sel      (fpu_sel),
    .addsub_result(addsub_result),
    .mul_result   (mul_result),
    .div_result   (div_result),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] f_add(
    input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h4080_0000 && b == 32'hBF80_0000)
      return 32'h4040_0000;
    return a + b + 32'h0000_1111;
  endfunction

  function automatic logic [31:0] f_mul(
    input logic [31:0] a, input logic [31:0] b);
    return (a * 32'd3) ^ b;
  endfunction

  function automatic logic [31:0] f_div(
    input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h4000_0000 && b == 32'h4040_0000)
      return 32'h3F2A_AAAB;
    return {a[15:0], b[31:16]} ^ 32'h5A5A_5A5A;
  endfunction

  // combinational unit stubs
  assign addsub_result = f_add(fpu_a, fpu_b);
  assign mul_result    = f_mul(fpu_a, fpu_b);
  assign div_result    = f_div(fpu_a, fpu_b);

  task automatic issue(input logic [1:0] op,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input logic [4:0] tag);
    int n;
    logic [31:0] beff;
    n = 0;
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_tag   = tag;
    while (bus.req_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 50) begin
      errors++;
      $display("FAIL accept_timeout req_ready=%b exp 1",
               bus.req_ready);
    end
    beff  = (op == 2'd1) ? {~b[31], b[30:0]} : b;
    e_tag = tag;
    if (op == 2'd3 && b[30:0] == 31'd0) begin
      e_lat = 1;
      e_nv  = a[30:0] == 31'd0;
      e_dz  = !e_nv;
      e_res = e_nv ? 32'h7FC0_0000
                   : {a[31] ^ b[31], 8'hFF, 23'd0};
    end else begin
      m_a   = a;
      m_b   = beff;
      e_dz  = 1'b0;
      e_nv  = 1'b0;
      case (op)
        2'd3: begin
          m_sel = 2'd2; e_lat = 8; e_res = f_div(a, beff);
        end
        2'd2: begin
          m_sel = 2'd1; e_lat = 2; e_res = f_mul(a, beff);
        end
        default: begin
          m_sel = 2'd0; e_lat = 1; e_res = f_add(a, beff);
        end
      endcase
    end
    @(posedge clk);
    #1;
    checks++;
    if ({fpu_a, fpu_b, fpu_sel} !== {m_a, m_b, m_sel}) begin
      errors++;
      $display("FAIL fpu_regs a=%h b=%h s=%0d exp %h %h %0d",
               fpu_a, fpu_b, fpu_sel, m_a, m_b, m_sel);
    end
    checks++;
    if (bus.req_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL accept_status rdy=%b busy=%b exp 0 1",
               bus.req_ready, busy);
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_a     = $urandom;
    bus.req_b     = $urandom;
  endtask

  task automatic await_rsp();
    int k;
    k = 0;
    do begin
      @(posedge clk);
      #1;
      k++;
    end while (bus.rsp_valid !== 1'b1 && k < 40);
    checks++;
    if (k != e_lat) begin
      errors++;
      $display("FAIL latency got %0d exp %0d", k, e_lat);
    end
    checks++;
    if (bus.rsp_result !== e_res) begin
      errors++;
      $display("FAIL result got %h exp %h",
               bus.rsp_result, e_res);
    end
    checks++;
    if (bus.rsp_tag !== e_tag) begin
      errors++;
      $display("FAIL tag got %0d exp %0d", bus.rsp_tag, e_tag);
    end
    checks++;
    if ({bus.rsp_dz, bus.rsp_nv} !== {e_dz, e_nv}) begin
      errors++;
      $display("FAIL flags dz/nv got %b%b exp %b%b",
               bus.rsp_dz, bus.rsp_nv, e_dz, e_nv);
    end
    checks++;
    if ({fpu_a, fpu_b, fpu_sel} !== {m_a, m_b, m_sel}) begin
      errors++;
      $display("FAIL fpu_hold a=%h b=%h s=%0d exp %h %h %0d",
               fpu_a, fpu_b, fpu_sel, m_a, m_b, m_sel);
    end
  endtask

  task automatic finish_rsp(input int hold);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== e_res ||
          bus.rsp_tag !== e_tag || bus.req_ready !== 1'b0 ||
          {bus.rsp_dz, bus.rsp_nv} !== {e_dz, e_nv}) begin
        errors++;
        $display("FAIL stall_hold v=%b r=%h t=%0d rdy=%b exp 1 %h %0d 0",
                 bus.rsp_valid, bus.rsp_result, bus.rsp_tag,
                 bus.req_ready, e_res, e_tag);
      end
    end
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1 ||
        busy !== 1'b0) begin
      errors++;
      $display("FAIL handshake v=%b rdy=%b busy=%b exp 0 1 0",
               bus.rsp_valid, bus.req_ready, busy);
    end
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_op    = 2'd0;
    bus.req_a     = 32'd0;
    bus.req_b     = 32'd0;
    bus.req_tag   = 5'd0;
    bus.rsp_ready = 1'b0;
    m_a = 32'd0; m_b = 32'd0; m_sel = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.req_ready, bus.rsp_valid, bus.rsp_result,
         bus.rsp_tag, bus.rsp_dz, bus.rsp_nv, busy,
         fpu_a, fpu_b, fpu_sel} !== '0) begin
      errors++;
      $display("FAIL reset_outputs rdy=%b v=%b busy=%b exp all 0",
               bus.req_ready, bus.rsp_valid, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.req_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release rdy=%b busy=%b exp 1 0",
               bus.req_ready, busy);
    end
  endtask

  task automatic test_div();
    bus.rsp_ready = 1'b1;
    issue(2'd3, 32'h4000_0000, 32'h4040_0000, 5'd9);
    await_rsp();
    finish_rsp(0);
  endtask

  task automatic test_sub();
    bus.rsp_ready = 1'b1;
    issue(2'd1, 32'h4080_0000, 32'h3F80_0000, 5'd4);
    await_rsp();
    finish_rsp(0);
  endtask

  task automatic test_div_zero();
    bus.rsp_ready = 1'b1;
    issue(2'd3, 32'hC000_0000, 32'h0000_0000, 5'd12);
    await_rsp();
    finish_rsp(0);
    issue(2'd3, 32'h0000_0000, 32'h8000_0000, 5'd13);
    await_rsp();
    finish_rsp(0);
  endtask

  task automatic test_backpressure();
    bus.rsp_ready = 1'b0;
    issue(2'd2, 32'h3FC0_0000, 32'h4000_0000, 5'd21);
    await_rsp();
    bus.req_valid = 1'b1;
    bus.req_op    = 2'd0;
    bus.req_a     = 32'h1234_5678;
    bus.req_b     = 32'h0000_0042;
    bus.req_tag   = 5'd22;
    finish_rsp(5);
    issue(2'd0, 32'h1234_5678, 32'h0000_0042, 5'd22);
    await_rsp();
    finish_rsp(0);
  endtask

  task automatic test_reset_mid();
    bit seen;
    bus.rsp_ready = 1'b1;
    issue(2'd3, 32'h4110_0000, 32'h4040_0000, 5'd5);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.req_ready, bus.rsp_valid, bus.rsp_result,
         bus.rsp_tag, bus.rsp_dz, bus.rsp_nv, busy,
         fpu_a, fpu_b, fpu_sel} !== '0) begin
      errors++;
      $display("FAIL async_reset rdy=%b busy=%b sel=%0d exp all 0",
               bus.req_ready, busy, fpu_sel);
    end
    m_a = 32'd0; m_b = 32'd0; m_sel = 2'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.req_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_release rdy=%b busy=%b exp 1 0",
               bus.req_ready, busy);
    end
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (bus.rsp_valid === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL aborted_rsp rsp_valid seen=1 exp 0");
    end
  endtask

  task automatic test_back_to_back();
    bus.rsp_ready = 1'b1;
    issue(2'd0, 32'h3F80_0000, 32'h4000_0000, 5'd3);
    await_rsp();
    finish_rsp(0);
    issue(2'd2, 32'h4040_0000, 32'h4080_0000, 5'd7);
    await_rsp();
    finish_rsp(0);
    issue(2'd3, 32'h40A0_0000, 32'h4000_0000, 5'd31);
    await_rsp();
    finish_rsp(0);
  endtask

  task automatic test_random();
    logic [1:0]  op;
    logic [31:0] a, b;
    int          hold;
    for (int i = 0; i < 30; i++) begin
      op   = 2'($urandom_range(0, 3));
      a    = $urandom;
      b    = $urandom;
      if (op == 2'd3 && $urandom_range(0, 2) == 0) begin
        b[30:0] = 31'd0;
        if ($urandom_range(0, 1) == 0) a[30:0] = 31'd0;
      end
      hold = $urandom_range(0, 3);
      bus.rsp_ready = (hold == 0);
      issue(op, a, b, 5'($urandom));
      await_rsp();
      finish_rsp(hold);
    end
  endtask

  initial begin
    test_reset();
    test_div();
    test_sub();
    test_div_zero();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
